// File: rtl/watch_setter.sv
// Date/time setting controller: captures live time into shadow registers, walks the
// user through each field with up/down editing, and loads the result back on commit.
module watch_setter #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk1sec,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_cancel,
  input  logic [7:0]  cur_year,
  input  logic [7:0]  cur_month,
  input  logic [7:0]  cur_day,
  input  logic [7:0]  cur_hour,
  input  logic [7:0]  cur_minute,
  input  logic [7:0]  cur_second,
  output logic        set_time,
  output logic [47:0] bin_time,
  output logic [2:0]  edit_field,
  output logic [7:0]  edit_value,
  output logic        blink
);

  localparam int unsigned CntW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_SEC - 1);

  typedef enum logic [2:0] {
    StIdle, StYear, StMonth, StDay, StHour, StMin, StSec, StCommit
  } state_e;

  state_e          state_q;
  logic [7:0]      yr_q, mo_q, dy_q, hr_q, mi_q, se_q;
  logic [CntW-1:0] cnt_q;
  logic            set_time_q;

  function automatic logic [7:0] max_day(input logic [7:0] m);
    case (m)
      8'd4, 8'd6, 8'd9, 8'd11: max_day = 8'd30;
      8'd2:                    max_day = 8'd28;
      default:                 max_day = 8'd31;
    endcase
  endfunction

  // Capture path: clamp live values into legal ranges, day against the clamped month.
  logic [7:0] cap_yr, cap_mo, cap_dy, cap_hr, cap_mi, cap_se, cap_md;
  always_comb begin
    cap_yr = (cur_year == 8'd0) ? 8'd1 : cur_year;
    cap_mo = (cur_month == 8'd0) ? 8'd1 : (cur_month > 8'd12) ? 8'd12 : cur_month;
    cap_md = max_day(cap_mo);
    cap_dy = (cur_day == 8'd0) ? 8'd1 : (cur_day > cap_md) ? cap_md : cur_day;
    cap_hr = (cur_hour > 8'd23) ? 8'd23 : cur_hour;
    cap_mi = (cur_minute > 8'd59) ? 8'd59 : cur_minute;
    cap_se = (cur_second > 8'd59) ? 8'd59 : cur_second;
  end

  // Edit path: wrap-around increment/decrement of the field selected by the state.
  logic [7:0] fmin, fmax, fcur, fnew, md_new, day_adj;
  always_comb begin
    fmin       = 8'd0;
    fmax       = 8'd0;
    fcur       = 8'd0;
    edit_field = 3'd0;
    case (state_q)
      StYear:  begin fmin = 8'd1; fmax = 8'd255;        fcur = yr_q; edit_field = 3'd1; end
      StMonth: begin fmin = 8'd1; fmax = 8'd12;         fcur = mo_q; edit_field = 3'd2; end
      StDay:   begin fmin = 8'd1; fmax = max_day(mo_q); fcur = dy_q; edit_field = 3'd3; end
      StHour:  begin fmin = 8'd0; fmax = 8'd23;         fcur = hr_q; edit_field = 3'd4; end
      StMin:   begin fmin = 8'd0; fmax = 8'd59;         fcur = mi_q; edit_field = 3'd5; end
      StSec:   begin fmin = 8'd0; fmax = 8'd59;         fcur = se_q; edit_field = 3'd6; end
      default: ;
    endcase
    if (btn_up) fnew = (fcur >= fmax) ? fmin : fcur + 8'd1;
    else        fnew = (fcur <= fmin) ? fmax : fcur - 8'd1;
    md_new  = max_day(fnew);
    day_adj = (dy_q > md_new) ? md_new : dy_q;
  end

  assign edit_value = fcur;
  // A reset landing on the commit cycle must suppress the load strobe immediately.
  assign set_time = set_time_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      {yr_q, mo_q, dy_q, hr_q, mi_q, se_q} <= '0;
      bin_time   <= '0;
      set_time_q <= 1'b0;
      blink      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          set_time_q <= 1'b0;
          blink      <= 1'b0;
          cnt_q      <= '0;
          if (btn_mode) begin
            {yr_q, mo_q, dy_q, hr_q, mi_q, se_q} <= {cap_yr, cap_mo, cap_dy, cap_hr, cap_mi, cap_se};
            state_q <= StYear;
            blink   <= 1'b1;
          end
        end
        StCommit: begin
          state_q    <= StIdle;
          set_time_q <= 1'b0;
        end
        default: begin
          if (btn_cancel) begin
            state_q <= StIdle;
            blink   <= 1'b0;
            cnt_q   <= '0;
          end else if (btn_mode) begin
            cnt_q <= '0;
            if (state_q == StSec) begin
              state_q    <= StCommit;
              set_time_q <= 1'b1;
              bin_time   <= {yr_q, mo_q, dy_q, hr_q, mi_q, se_q};
              blink      <= 1'b0;
            end else begin
              state_q <= state_e'(state_q + 3'd1);
              blink   <= 1'b1;
            end
          end else if (btn_up || btn_down) begin
            cnt_q <= '0;
            blink <= 1'b1;
            if (btn_up ^ btn_down) begin
              case (state_q)
                StYear:  yr_q <= fnew;
                StMonth: begin mo_q <= fnew; dy_q <= day_adj; end
                StDay:   dy_q <= fnew;
                StHour:  hr_q <= fnew;
                StMin:   mi_q <= fnew;
                default: se_q <= fnew;
              endcase
            end
          end else if (clk1sec) begin
            if (cnt_q == CntLast) begin
              state_q <= StIdle;
              blink   <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              blink <= ~blink;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watch_setter.sv
// Bench for watch_setter: a table of button vectors with hand-derived expected outputs,
// pushed to a scoreboard queue on each drive and checked once the edge has taken effect.
module tb_watch_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clk1sec = 1'b0;
  logic        btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_cancel = 1'b0;
  logic [7:0]  cur_year = '0, cur_month = '0, cur_day = '0;
  logic [7:0]  cur_hour = '0, cur_minute = '0, cur_second = '0;
  logic        set_time, blink;
  logic [47:0] bin_time;
  logic [2:0]  edit_field;
  logic [7:0]  edit_value;

  watch_setter #(.TIMEOUT_SEC(3)) dut (
    .clk(clk), .rst(rst), .clk1sec(clk1sec),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_cancel(btn_cancel),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .set_time(set_time), .bin_time(bin_time), .edit_field(edit_field),
    .edit_value(edit_value), .blink(blink)
  );

  always #5 clk = ~clk;

  // Input bits: {rst, clk1sec, cancel, mode, up, down}
  localparam logic [5:0] N = 6'b000000, R = 6'b100000, S = 6'b010000, C = 6'b001000;
  localparam logic [5:0] M = 6'b000100, U = 6'b000010, D = 6'b000001;

  localparam logic [47:0] C0 = 48'h0;
  localparam logic [47:0] CA = 48'h18021D0A1E00;  // 24-02-29 10:30:00
  localparam logic [47:0] CB = 48'h05011F000000;  // 5-01-31
  localparam logic [47:0] CC = 48'h05060708090A;
  localparam logic [47:0] CD = 48'hC80D281E4663;  // 200,13,40,30,70,99: all over range
  localparam logic [47:0] B1 = 48'h18021C0A1E00;

  typedef struct {
    string       name;
    logic [5:0]  in;
    logic [47:0] cur;
    logic [2:0]  f;
    logic [7:0]  v;
    logic        b;
    logic        st;
    logic [47:0] bin;
  } vec_t;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [7:0]  v;
    logic        b;
    logic        st;
    logic [47:0] bin;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic add(input string n, input logic [5:0] in, input logic [47:0] cur,
                     input logic [2:0] f, input logic [7:0] v, input logic b,
                     input logic st, input logic [47:0] bin);
    vec_t x;
    x.name = n; x.in = in; x.cur = cur; x.f = f; x.v = v; x.b = b; x.st = st; x.bin = bin;
    vecs.push_back(x);
  endtask

  task automatic check_front();
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow: got empty queue, want one entry");
      return;
    end
    e = exp_q.pop_front();
    if ({edit_field, edit_value, blink, set_time, bin_time} !== {e.f, e.v, e.b, e.st, e.bin}) begin
      n_fail++;
      $display("FAIL %s: got field=%0d value=%0d blink=%b set_time=%b bin=%h, want field=%0d value=%0d blink=%b set_time=%b bin=%h",
               e.name, edit_field, edit_value, blink, set_time, bin_time,
               e.f, e.v, e.b, e.st, e.bin);
    end
  endtask

  task automatic apply(input vec_t x);
    exp_t e;
    {rst, clk1sec, btn_cancel, btn_mode, btn_up, btn_down} = x.in;
    {cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second} = x.cur;
    @(posedge clk);
    #1;
    e.name = x.name; e.f = x.f; e.v = x.v; e.b = x.b; e.st = x.st; e.bin = x.bin;
    exp_q.push_back(e);
    {rst, clk1sec, btn_cancel, btn_mode, btn_up, btn_down} = N;
    @(negedge clk);
    check_front();
  endtask

  initial begin
    // Reset, idle buttons ignored, capture of all-zero time, year wrap both ways
    add("reset",          R,     C0, 3'd0, 8'd0,   1'b0, 1'b0, C0);
    add("idle_up",        U,     C0, 3'd0, 8'd0,   1'b0, 1'b0, C0);
    add("idle_cancel",    C,     C0, 3'd0, 8'd0,   1'b0, 1'b0, C0);
    add("cap_zero_year",  M,     C0, 3'd1, 8'd1,   1'b1, 1'b0, C0);
    add("year_down_wrap", D,     C0, 3'd1, 8'd255, 1'b1, 1'b0, C0);
    add("year_up_wrap",   U,     C0, 3'd1, 8'd1,   1'b1, 1'b0, C0);
    add("up_and_down",    U | D, C0, 3'd1, 8'd1,   1'b1, 1'b0, C0);
    add("sec_blink",      S,     C0, 3'd1, 8'd1,   1'b0, 1'b0, C0);
    add("to_month",       M,     C0, 3'd2, 8'd1,   1'b1, 1'b0, C0);
    add("month_wrap",     D,     C0, 3'd2, 8'd12,  1'b1, 1'b0, C0);
    add("to_day",         M,     C0, 3'd3, 8'd1,   1'b1, 1'b0, C0);
    add("day_down_wrap",  D,     C0, 3'd3, 8'd31,  1'b1, 1'b0, C0);
    add("cancel_day",     C,     C0, 3'd0, 8'd0,   1'b0, 1'b0, C0);
    // Leap-day capture clamps to 28, then commit
    add("cap_year24",     M,     CA, 3'd1, 8'd24,  1'b1, 1'b0, C0);
    add("cap_month2",     M,     CA, 3'd2, 8'd2,   1'b1, 1'b0, C0);
    add("cap_day28",      M,     CA, 3'd3, 8'd28,  1'b1, 1'b0, C0);
    add("cap_hour10",     M,     CA, 3'd4, 8'd10,  1'b1, 1'b0, C0);
    add("cap_min30",      M,     CA, 3'd5, 8'd30,  1'b1, 1'b0, C0);
    add("cap_sec0",       M,     CA, 3'd6, 8'd0,   1'b1, 1'b0, C0);
    add("commit_a",       M,     CA, 3'd0, 8'd0,   1'b0, 1'b1, B1);
    add("idle_after_a",   N,     CA, 3'd0, 8'd0,   1'b0, 1'b0, B1);
    // Month change clamps day
    add("cap_b",          M,     CB, 3'd1, 8'd5,   1'b1, 1'b0, B1);
    add("b_month1",       M,     CB, 3'd2, 8'd1,   1'b1, 1'b0, B1);
    add("b_month_up",     U,     CB, 3'd2, 8'd2,   1'b1, 1'b0, B1);
    add("b_month_down",   D,     CB, 3'd2, 8'd1,   1'b1, 1'b0, B1);
    add("b_day_clamped",  M,     CB, 3'd3, 8'd28,  1'b1, 1'b0, B1);
    add("b_cancel",       C,     CB, 3'd0, 8'd0,   1'b0, 1'b0, B1);
    // Six mode pulses commit 05060708090A
    add("c_year",         M,     CC, 3'd1, 8'd5,   1'b1, 1'b0, B1);
    add("c_month",        M,     CC, 3'd2, 8'd6,   1'b1, 1'b0, B1);
    add("c_day",          M,     CC, 3'd3, 8'd7,   1'b1, 1'b0, B1);
    add("c_hour",         M,     CC, 3'd4, 8'd8,   1'b1, 1'b0, B1);
    add("c_min",          M,     CC, 3'd5, 8'd9,   1'b1, 1'b0, B1);
    add("c_sec",          M,     CC, 3'd6, 8'd10,  1'b1, 1'b0, B1);
    add("c_commit",       M,     CC, 3'd0, 8'd0,   1'b0, 1'b1, CC);
    add("c_idle",         N,     CC, 3'd0, 8'd0,   1'b0, 1'b0, CC);
    // Over-range capture clamps to maxima; hour/min/sec wraps
    add("d_year",         M,     CD, 3'd1, 8'd200, 1'b1, 1'b0, CC);
    add("d_month",        M,     CD, 3'd2, 8'd12,  1'b1, 1'b0, CC);
    add("d_day",          M,     CD, 3'd3, 8'd31,  1'b1, 1'b0, CC);
    add("d_hour",         M,     CD, 3'd4, 8'd23,  1'b1, 1'b0, CC);
    add("d_hour_wrap",    U,     CD, 3'd4, 8'd0,   1'b1, 1'b0, CC);
    add("d_min",          M,     CD, 3'd5, 8'd59,  1'b1, 1'b0, CC);
    add("d_min_wrap",     U,     CD, 3'd5, 8'd0,   1'b1, 1'b0, CC);
    add("d_sec",          M,     CD, 3'd6, 8'd59,  1'b1, 1'b0, CC);
    add("d_sec_wrap_up",  U,     CD, 3'd6, 8'd0,   1'b1, 1'b0, CC);
    add("d_sec_wrap_dn",  D,     CD, 3'd6, 8'd59,  1'b1, 1'b0, CC);
    add("d_cancel",       C,     CD, 3'd0, 8'd0,   1'b0, 1'b0, CC);
    // Timeout after three idle seconds
    add("t_enter",        M,     CC, 3'd1, 8'd5,   1'b1, 1'b0, CC);
    add("t_sec1",         S,     CC, 3'd1, 8'd5,   1'b0, 1'b0, CC);
    add("t_sec2",         S,     CC, 3'd1, 8'd5,   1'b1, 1'b0, CC);
    add("t_sec3_abort",   S,     CC, 3'd0, 8'd0,   1'b0, 1'b0, CC);
    // Button coincident with the would-be timeout second wins
    add("w_enter",        M,     CC, 3'd1, 8'd5,   1'b1, 1'b0, CC);
    add("w_sec1",         S,     CC, 3'd1, 8'd5,   1'b0, 1'b0, CC);
    add("w_sec2",         S,     CC, 3'd1, 8'd5,   1'b1, 1'b0, CC);
    add("w_sec3_up",      S | U, CC, 3'd1, 8'd6,   1'b1, 1'b0, CC);
    add("w_sec4",         S,     CC, 3'd1, 8'd6,   1'b0, 1'b0, CC);
    add("w_sec5",         S,     CC, 3'd1, 8'd6,   1'b1, 1'b0, CC);
    add("w_sec6_abort",   S,     CC, 3'd0, 8'd0,   1'b0, 1'b0, CC);
    // Cancel beats mode in E_SEC: no commit
    add("x_year",         M,     CC, 3'd1, 8'd5,   1'b1, 1'b0, CC);
    add("x_month",        M,     CC, 3'd2, 8'd6,   1'b1, 1'b0, CC);
    add("x_day",          M,     CC, 3'd3, 8'd7,   1'b1, 1'b0, CC);
    add("x_hour",         M,     CC, 3'd4, 8'd8,   1'b1, 1'b0, CC);
    add("x_min",          M,     CC, 3'd5, 8'd9,   1'b1, 1'b0, CC);
    add("x_sec",          M,     CC, 3'd6, 8'd10,  1'b1, 1'b0, CC);
    add("x_cancel_mode",  C | M, CC, 3'd0, 8'd0,   1'b0, 1'b0, CC);
    // Reset beats mode in E_SEC
    add("r_year",         M,     CC, 3'd1, 8'd5,   1'b1, 1'b0, CC);
    add("r_month",        M,     CC, 3'd2, 8'd6,   1'b1, 1'b0, CC);
    add("r_day",          M,     CC, 3'd3, 8'd7,   1'b1, 1'b0, CC);
    add("r_hour",         M,     CC, 3'd4, 8'd8,   1'b1, 1'b0, CC);
    add("r_min",          M,     CC, 3'd5, 8'd9,   1'b1, 1'b0, CC);
    add("r_sec",          M,     CC, 3'd6, 8'd10,  1'b1, 1'b0, CC);
    add("r_rst_mode",     R | M, CC, 3'd0, 8'd0,   1'b0, 1'b0, C0);
    // Walk into COMMIT again for the reset-in-commit sequence below
    add("k_year",         M,     CC, 3'd1, 8'd5,   1'b1, 1'b0, C0);
    add("k_month",        M,     CC, 3'd2, 8'd6,   1'b1, 1'b0, C0);
    add("k_day",          M,     CC, 3'd3, 8'd7,   1'b1, 1'b0, C0);
    add("k_hour",         M,     CC, 3'd4, 8'd8,   1'b1, 1'b0, C0);
    add("k_min",          M,     CC, 3'd5, 8'd9,   1'b1, 1'b0, C0);
    add("k_sec",          M,     CC, 3'd6, 8'd10,  1'b1, 1'b0, C0);
    add("k_commit",       M,     CC, 3'd0, 8'd0,   1'b0, 1'b1, CC);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset raised during the COMMIT cycle: strobe suppressed at once, then all cleared
    rst = 1'b1;
    #1;
    n_cmp++;
    if (set_time !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_commit_strobe: got set_time=%b, want 0", set_time);
    end
    begin
      vec_t x;
      x.name = "rst_in_commit_after"; x.in = R; x.cur = CC;
      x.f = 3'd0; x.v = 8'd0; x.b = 1'b0; x.st = 1'b0; x.bin = C0;
      apply(x);
      x.name = "idle_after_rst"; x.in = N;
      apply(x);
    end

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/watch_setter.md
WATCH_SETTER -- requirements
Module: watch_setter

Interface
REQ-001 Parameter TIMEOUT_SEC, default 10: whole seconds of button inactivity that abort an edit session.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clk1sec  input  1  one-cycle pulse once per second.
REQ-005 btn_mode, btn_up, btn_down, btn_cancel  input  1 each  debounced one-cycle button pulses.
REQ-006 cur_year, cur_month, cur_day, cur_hour, cur_minute, cur_second  input  8 each  live time from the watch counter.
REQ-007 set_time  output  1  one-cycle load strobe to the watch counter.
REQ-008 bin_time  output  48  {year, month, day, hour, minute, second}, 8 bits per field, year in [47:40].
REQ-009 edit_field  output  3  0=none, 1=year, 2=month, 3=day, 4=hour, 5=minute, 6=second.
REQ-010 edit_value  output  8  shadow value of the field being edited; 0 when edit_field=0.
REQ-011 blink  output  1  display blink phase for the edited field.

Function
REQ-012 FSM states: IDLE, E_YEAR, E_MONTH, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT.
REQ-013 IDLE + btn_mode: capture cur_* into shadow registers, clamped to legal range (REQ-016); next state E_YEAR.
REQ-014 IDLE: btn_up/btn_down/btn_cancel ignored; set_time=0.
REQ-015 Edit states: btn_mode advances E_YEAR->E_MONTH->E_DAY->E_HOUR->E_MIN->E_SEC->COMMIT.
REQ-016 Legal ranges: year 1..255, month 1..12, day 1..max_day, hour 0..23, minute 0..59, second 0..59.
REQ-017 max_day: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28 for 2.
REQ-018 Capture clamping: a field below its minimum takes the minimum; a field above its maximum takes the maximum; max_day is evaluated on the clamped month.
REQ-019 btn_up increments the edited shadow field; at the maximum it wraps to the minimum (year 255->1, month 12->1, day max_day->1, hour 23->0, min/sec 59->0).
REQ-020 btn_down decrements; at the minimum it wraps to the maximum (year 1->255, month 1->12, day 1->max_day, hour 0->23, min/sec 0->59).
REQ-021 Whenever the shadow month changes, shadow day > new max_day is clamped to new max_day in the same cycle.
REQ-022 Same-cycle priority: btn_cancel > btn_mode > btn_up/btn_down; btn_up and btn_down together with neither higher button cause no change.
REQ-023 btn_cancel in any edit state: next state IDLE, no set_time, shadow values discarded.
REQ-024 COMMIT lasts exactly one cycle: set_time=1 and bin_time=shadow fields in that cycle; next state IDLE.
REQ-025 Latency: btn_mode in E_SEC at cycle N -> set_time high in cycle N+1 only.
REQ-026 bin_time is registered; it updates only on entry to COMMIT and holds its value otherwise.
REQ-027 Timeout counter: cleared on entering E_YEAR and on any button pulse in an edit state; increments on clk1sec in edit states; reaching TIMEOUT_SEC forces IDLE without set_time.
REQ-028 A button pulse coincident with the clk1sec pulse that would reach TIMEOUT_SEC wins: the counter clears and no abort occurs.
REQ-029 blink: 0 in IDLE/COMMIT; set to 1 on entering E_YEAR; toggles on each clk1sec in edit states; set to 1 on any edit-state button pulse.
REQ-030 edit_field/edit_value are combinational from state and shadow registers.

Reset
REQ-031 rst=1 at a rising edge: state IDLE, all shadow fields 0, bin_time 0, set_time 0, blink 0, timeout counter 0; overrides all buttons.
REQ-032 rst asserted mid-edit or in COMMIT aborts the session; no set_time is produced in that cycle or after.

Verification
REQ-033 cur=(24,2,29,10,30,0), btn_mode -> shadow (24,2,28,10,30,0), edit_field=1, edit_value=24.
REQ-034 Capture after reset (all cur_*=0) -> shadow (1,1,1,0,0,0); btn_down on year -> 255; btn_up -> 1.
REQ-035 Shadow month=1, day=31; btn_up on month -> month 2, day 28; btn_down on month -> month 1, day 28.
REQ-036 Six btn_mode pulses after entry with shadow (5,6,7,8,9,10) -> set_time high exactly one cycle, bin_time=48'h05060708090A, then IDLE.
REQ-037 TIMEOUT_SEC=3, no buttons for 3 clk1sec pulses -> IDLE, set_time never asserted; btn_cancel plus btn_mode same cycle -> IDLE, no commit.
REQ-038 rst during E_SEC plus btn_mode same cycle -> IDLE next cycle, set_time=0, bin_time=0.
